alu_uart_sequencer: RTL and testbench
=====================================

ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: operand/result width in bits; must be a multiple of NB_BYTE, at most 64.
REQ-002 SHALL have parameter NB_BYTE, default 8: UART byte width.
REQ-003 SHALL have parameter NB_OP, default 6: opcode width; must be at most NB_BYTE.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout in clock cycles; must be at least 2.
REQ-005 SHALL have port i_clock  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port i_rx_valid  input  1: one-cycle pulse when a received byte is present on i_rx_data.
REQ-008 SHALL have port i_rx_data  input  NB_BYTE: received byte.
REQ-009 SHALL have port i_tx_ready  input  1: UART transmitter accepts a byte this cycle.
REQ-010 SHALL have port o_tx_valid  output  1: byte on o_tx_data is offered to the transmitter.
REQ-011 SHALL have port o_tx_data  output  NB_BYTE: result byte to transmit.
REQ-012 SHALL have port o_busy  output  1: high in COMPUTE and SEND.
REQ-013 SHALL have port o_timeout  output  1: one-cycle pulse when a partial frame is discarded.
REQ-014 SHALL have port o_overrun  output  1: one-cycle pulse when an rx byte is dropped while busy.

Function
REQ-015 SHALL define N_BYTES = NB_DATA/NB_BYTE; each operand is received as N_BYTES bytes, least-significant byte first.
REQ-016 SHALL implement states COLLECT_A, COLLECT_B, COLLECT_OP, COMPUTE, SEND.
REQ-017 SHALL count accepted bytes with a byte counter; in COLLECT_A or COLLECT_B, the byte with index N_BYTES-1 advances the state and clears the counter.
REQ-018 In COLLECT_OP, one accepted byte SHALL load opcode = i_rx_data[NB_OP-1:0] and advance to COMPUTE.
REQ-019 COMPUTE SHALL last exactly one cycle, register the ALU result into a shift register, and enter SEND.
REQ-020 Latency: if the opcode byte is sampled at edge n, o_tx_valid SHALL be high from edge n+2.
REQ-021 SEND SHALL offer result bytes LSB first; a byte transfers on any edge where o_tx_valid and i_tx_ready are both high.
REQ-022 o_tx_data and o_tx_valid SHALL stay stable until the byte transfers; i_tx_ready held low SHALL stall SEND indefinitely with no timeout.
REQ-023 After transfer of byte N_BYTES-1, the block SHALL deassert o_tx_valid on the next cycle and return to COLLECT_A.
REQ-024 Timeout counter SHALL reset on every accepted byte and run only in a COLLECT state after at least one byte of the frame has been accepted.
REQ-025 On reaching TIMEOUT_CYCLES, the block SHALL discard A, B and the counter, pulse o_timeout, and return to COLLECT_A.
REQ-026 If a byte arrives in the same cycle as timeout expiry, the byte SHALL win: it is accepted and no timeout occurs.
REQ-027 An i_rx_valid in COMPUTE or SEND SHALL be dropped and SHALL pulse o_overrun in the next cycle; state is unaffected.
REQ-028 An illegal state encoding SHALL recover to COLLECT_A with all registers cleared.

Reset
REQ-029 While i_reset_n is low, the block SHALL force: state COLLECT_A; operands, opcode, counters and shift register zero; o_tx_valid, o_busy, o_timeout, o_overrun 0; o_tx_data 0.
REQ-030 Reset asserted mid-frame or mid-SEND SHALL abort immediately; the first frame after deassertion SHALL be processed normally.

Structure
REQ-031 State encodings, NB_BYTE and the opcode constants SHALL live in the shared ALU/UART package.
REQ-032 The block SHALL instantiate the existing alu module as its only sub-module, with operands and opcode registered and N_BITS_DATA=NB_DATA.

Verification
REQ-033 NB_DATA=16, i_tx_ready=1: send bytes 34 12 01 00 20 (ADD 6'b100000) -> o_tx_data 35 then 12; o_tx_valid first high 2 cycles after the opcode byte.
REQ-034 NB_DATA=8: send 05 03 then SUB opcode, with i_tx_ready low for 10 cycles -> o_tx_valid=1 and o_tx_data=02 held stable for all 10 cycles, then exactly one transfer.
REQ-035 TIMEOUT_CYCLES=16: send one byte, then idle for 16 cycles -> o_timeout pulses once; the following full frame computes correctly.
REQ-036 Pulse i_rx_valid during SEND -> o_overrun pulses once and the transmitted result bytes are unchanged.
REQ-037 Pull i_reset_n low after the A bytes -> all outputs are 0 asynchronously; a new complete frame afterwards yields the correct result.

Source files
------------

// File: rtl/alu_uart_sequencer_pkg.sv
// alu_uart_sequencer_pkg: shared ALU/UART byte width, opcodes and sequencer state encodings
package alu_uart_sequencer_pkg;
    localparam int PKG_NB_BYTE = 8;
    localparam int PKG_NB_OP = 6;
    localparam logic [PKG_NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [PKG_NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [PKG_NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [PKG_NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [PKG_NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [PKG_NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [PKG_NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [PKG_NB_OP-1:0] OP_SRL = 6'b000010;
    typedef enum logic [2:0] {
        COLLECT_A  = 3'd0,
        COLLECT_B  = 3'd1,
        COLLECT_OP = 3'd2,
        COMPUTE    = 3'd3,
        SEND       = 3'd4
    } seq_state_t;
endpackage

// File: rtl/alu_uart_sequencer_alu.sv
// alu: combinational ALU; unknown opcodes yield zero
module alu
    import alu_uart_sequencer_pkg::*;
#(
    parameter int N_BITS_DATA = 8
) (
    input  logic [N_BITS_DATA-1:0] i_data_a,
    input  logic [N_BITS_DATA-1:0] i_data_b,
    input  logic [PKG_NB_OP-1:0]   i_op,
    output logic [N_BITS_DATA-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD: o_result = i_data_a + i_data_b;
            OP_SUB: o_result = i_data_a - i_data_b;
            OP_AND: o_result = i_data_a & i_data_b;
            OP_OR:  o_result = i_data_a | i_data_b;
            OP_XOR: o_result = i_data_a ^ i_data_b;
            OP_NOR: o_result = ~(i_data_a | i_data_b);
            OP_SRA: o_result = $signed(i_data_a) >>> i_data_b;
            OP_SRL: o_result = i_data_a >> i_data_b;
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects A, B and opcode bytes from a UART, runs the ALU and streams the result back LSB first
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_BYTE = PKG_NB_BYTE,
    parameter int NB_OP = PKG_NB_OP,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_tx_ready,
    output logic               o_tx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
    localparam int NB_TO = $clog2(TIMEOUT_CYCLES);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);
    localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT_CYCLES - 1);

    seq_state_t state, next_state;
    logic [NB_DATA-1:0] data_a, data_b, alu_result, tx_shift;
    logic [NB_OP-1:0] opcode;
    logic [NB_CNT-1:0] byte_cnt;
    logic [NB_TO-1:0] to_cnt;
    logic collecting, accept, started, expired, last_byte, tx_fire, legal;

    assign collecting = state inside {COLLECT_A, COLLECT_B, COLLECT_OP};
    assign legal = collecting || state inside {COMPUTE, SEND};
    assign accept = collecting && i_rx_valid;
    // a frame is in progress once any byte of it has been accepted
    assign started = collecting && (state != COLLECT_A || byte_cnt != '0);
    assign expired = started && !accept && to_cnt == TO_LAST;
    assign last_byte = byte_cnt == LAST_BYTE;
    assign tx_fire = o_tx_valid && i_tx_ready;
    assign o_busy = state inside {COMPUTE, SEND};
    assign o_tx_data = tx_shift[byte_cnt*NB_BYTE +: NB_BYTE];

    alu #(.N_BITS_DATA(NB_DATA)) u_alu (
        .i_data_a(data_a),
        .i_data_b(data_b),
        .i_op    (PKG_NB_OP'(opcode)),
        .o_result(alu_result)
    );

    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) state <= COLLECT_A;
        else state <= next_state;

    always_comb begin
        next_state = COLLECT_A;
        case (state)
            COLLECT_A:  next_state = expired ? COLLECT_A : (accept && last_byte) ? COLLECT_B : COLLECT_A;
            COLLECT_B:  next_state = expired ? COLLECT_A : (accept && last_byte) ? COLLECT_OP : COLLECT_B;
            COLLECT_OP: next_state = expired ? COLLECT_A : accept ? COMPUTE : COLLECT_OP;
            COMPUTE:    next_state = SEND;
            SEND:       next_state = (tx_fire && last_byte) ? COLLECT_A : SEND;
            default:    next_state = COLLECT_A;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_a     <= '0;
            data_b     <= '0;
            opcode     <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            tx_shift   <= '0;
            o_tx_valid <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else if (!legal || expired) begin
            data_a     <= '0;
            data_b     <= '0;
            opcode     <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            tx_shift   <= '0;
            o_tx_valid <= 1'b0;
            o_timeout  <= expired;
            o_overrun  <= 1'b0;
        end else begin
            o_timeout  <= 1'b0;
            o_overrun  <= i_rx_valid && o_busy;
            to_cnt     <= (accept || !started) ? '0 : to_cnt + 1'b1;
            o_tx_valid <= tx_fire ? !last_byte : (o_tx_valid || state == SEND);
            if (accept) begin
                byte_cnt <= (state == COLLECT_OP || last_byte) ? '0 : byte_cnt + 1'b1;
                if (state == COLLECT_A) data_a[byte_cnt*NB_BYTE +: NB_BYTE] <= i_rx_data;
                if (state == COLLECT_B) data_b[byte_cnt*NB_BYTE +: NB_BYTE] <= i_rx_data;
                if (state == COLLECT_OP) opcode <= i_rx_data[NB_OP-1:0];
            end
            if (state == COMPUTE) tx_shift <= alu_result;
            if (tx_fire) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: scoreboard bench for the 16-bit sequencer with a short inter-byte timeout
module tb_alu_uart_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic tx_valid, busy, timeout, overrun;
    int total = 0;
    int passed = 0;
    int tcount = 0;
    int ocount = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_sequencer #(.NB_DATA(16), .NB_BYTE(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_rx_valid(rx_valid),
        .i_rx_data (rx_data),
        .i_tx_ready(tx_ready),
        .o_tx_valid(tx_valid),
        .o_tx_data (tx_data),
        .o_busy    (busy),
        .o_timeout (timeout),
        .o_overrun (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte(op);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            tick(1);
            n++;
        end
        check("idle_reached", 32'(n < 100), 1);
    endtask

    always @(negedge clk) begin
        if (timeout) tcount++;
        if (overrun) ocount++;
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL tx_extra: got %h with no byte expected", tx_data);
            end else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_overrun", 32'(overrun), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        // ADD 0x1234 + 0x0001, latency check
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h12);
        send_frame(16'h1234, 16'h0001, 8'h20);
        check("lat_edge_n", 32'(tx_valid), 0);
        tick(1);
        check("lat_edge_n1", 32'(tx_valid), 0);
        check("busy_send", 32'(busy), 1);
        tick(1);
        check("lat_edge_n2", 32'(tx_valid), 1);
        check("first_byte", 32'(tx_data), 32'h35);
        wait_idle();
        // SUB 5 - 3 with the transmitter stalled for 10 cycles
        tx_ready = 1'b0;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
        send_frame(16'h0005, 16'h0003, 8'h22);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(tx_valid), 1);
            check("stall_data", 32'(tx_data), 32'h02);
            tick(1);
        end
        tx_ready = 1'b1;
        wait_idle();
        check("no_timeout_yet", tcount, 0);
        // single byte then idle: timeout on the 16th idle edge
        send_byte(8'hAA);
        tick(15);
        check("timeout_early", 32'(timeout), 0);
        tick(1);
        check("timeout_pulse", 32'(timeout), 1);
        tick(1);
        check("timeout_single", 32'(timeout), 0);
        tick(5);
        check("timeout_count", tcount, 1);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        send_frame(16'h00FF, 16'h0F0F, 8'h26);
        wait_idle();
        // byte arriving exactly at expiry wins
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        send_byte(8'h01);
        tick(15);
        send_byte(8'h00);
        check("byte_wins", 32'(timeout), 0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        wait_idle();
        check("byte_wins_count", tcount, 1);
        // rx byte during SEND is dropped and flagged
        tx_ready = 1'b0;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send_frame(16'h1200, 16'h0034, 8'h25);
        tick(3);
        send_byte(8'hFF);
        check("overrun_pulse", 32'(overrun), 1);
        tick(1);
        check("overrun_single", 32'(overrun), 0);
        tx_ready = 1'b1;
        wait_idle();
        check("overrun_count", ocount, 1);
        // asynchronous reset in the middle of SEND
        tx_ready = 1'b0;
        send_frame(16'h0101, 16'h0101, 8'h20);
        tick(3);
        check("pre_abort_valid", 32'(tx_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", 32'(tx_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_tx_data", 32'(tx_data), 0);
        tick(1);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick(1);
        // asynchronous reset after the A bytes, then a clean frame
        send_byte(8'h77);
        send_byte(8'h66);
        #2;
        rst_n = 1'b0;
        #1;
        check("midA_tx_valid", 32'(tx_valid), 0);
        check("midA_busy", 32'(busy), 0);
        check("midA_timeout", 32'(timeout), 0);
        check("midA_overrun", 32'(overrun), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h0F);
        send_frame(16'h1000, 16'h0001, 8'h22);
        wait_idle();
        tick(20);
        check("final_timeouts", tcount, 1);
        check("final_overruns", ocount, 1);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
